// File: rtl/parallel_pipe.sv
// Two-stage, multi-lane unsigned ALU pipeline with add/sub/mul/max, optional
// saturation, per-lane overflow flags and a delivered-result counter.
module parallel_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [LANES*WIDTH-1:0]   x,
  input  logic [LANES*WIDTH-1:0]   y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   r,
  output logic [LANES-1:0]         ovf,
  output logic [CNT_W-1:0]         cnt
);

  localparam int DW = LANES * WIDTH;

  // Handshake: a beat moves across an interface on a rising edge where valid
  // and ready are both 1; valid never waits on ready, and a stage refills in
  // the same cycle it drains.
  logic               r_s1_valid;
  logic [1:0]         r_s1_op;
  logic [DW-1:0]      r_s1_x;
  logic [DW-1:0]      r_s1_y;
  logic               r_s2_valid;
  logic [DW-1:0]      r_s2_r;
  logic [LANES-1:0]   r_s2_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [DW-1:0]      w_res;
  logic [LANES-1:0]   w_ovf;

  assign w_s2_adv  = r_s2_valid & out_ready;
  assign w_s1_adv  = r_s1_valid & (~r_s2_valid | w_s2_adv);
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign out_valid = r_s2_valid;
  assign r         = r_s2_r;
  assign ovf       = r_s2_ovf;
  assign cnt       = r_cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_r;
    logic               w_o;

    assign w_a    = r_s1_x[k*WIDTH +: WIDTH];
    assign w_b    = r_s1_y[k*WIDTH +: WIDTH];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    // Top bit of the widened difference is the borrow (x < y).
    assign w_dif  = {1'b0, w_a} - {1'b0, w_b};
    assign w_prod = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};

    always_comb begin
      w_r = '0;
      w_o = 1'b0;
      case (r_s1_op)
        2'b00: begin
          w_r = w_sum[WIDTH-1:0];
          w_o = w_sum[WIDTH];
          if (SAT != 0 && w_o) w_r = '1;
        end
        2'b01: begin
          w_r = w_dif[WIDTH-1:0];
          w_o = w_dif[WIDTH];
          if (SAT != 0 && w_o) w_r = '0;
        end
        2'b10: begin
          w_r = w_prod[WIDTH-1:0];
          w_o = |w_prod[2*WIDTH-1:WIDTH];
          if (SAT != 0 && w_o) w_r = '1;
        end
        default: begin
          w_r = (w_a > w_b) ? w_a : w_b;
          w_o = 1'b0;
        end
      endcase
    end

    assign w_res[k*WIDTH +: WIDTH] = w_r;
    assign w_ovf[k]                = w_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s2_ovf   <= '0;
      r_cnt      <= '0;
    end else begin
      // When in_ready is high S1 is empty or draining, so it takes in_valid as-is.
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op <= op;
          r_s1_x  <= x;
          r_s1_y  <= y;
        end
      end
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_r     <= w_res;
        r_s2_ovf   <= w_ovf;
      end else if (w_s2_adv) begin
        r_s2_valid <= 1'b0;
      end
      if (w_s2_adv) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parallel_pipe.sv
// Bench for parallel_pipe: three instances (wrap, saturating, 4-bit counter)
// share stimulus and are checked against a lane-by-lane arithmetic model.
module tb_parallel_pipe;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DW    = LANES * WIDTH;
  localparam int RW    = DW + LANES;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            out_ready;
  logic [1:0]      op;
  logic [DW-1:0]   x;
  logic [DW-1:0]   y;

  logic            in_ready0, in_ready1, in_ready2;
  logic            out_valid0, out_valid1, out_valid2;
  logic [DW-1:0]   r0, r1, r2;
  logic [3:0]      ovf0, ovf1, ovf2;
  logic [15:0]     cnt0, cnt1;
  logic [3:0]      cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] exp0_q[$];
  logic [RW-1:0] exp1_q[$];
  logic [RW-1:0] obs0_q[$];
  logic [RW-1:0] obs1_q[$];

  always #5 clk = ~clk;

  parallel_pipe #(.LANES(LANES), .WIDTH(WIDTH), .SAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
    .x(x), .y(y), .out_valid(out_valid0), .out_ready(out_ready), .r(r0),
    .ovf(ovf0), .cnt(cnt0)
  );

  parallel_pipe #(.LANES(LANES), .WIDTH(WIDTH), .SAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .x(x), .y(y), .out_valid(out_valid1), .out_ready(out_ready), .r(r1),
    .ovf(ovf1), .cnt(cnt1)
  );

  parallel_pipe #(.LANES(LANES), .WIDTH(WIDTH), .SAT(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .x(x), .y(y), .out_valid(out_valid2), .out_ready(out_ready), .r(r2),
    .ovf(ovf2), .cnt(cnt2)
  );

  // Reference: each lane evaluated with plain integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [1:0] f_op, input logic [DW-1:0] fx,
                                          input logic [DW-1:0] fy, input bit sat);
    logic [DW-1:0]    res;
    logic [LANES-1:0] fl;
    int a, b, v, top, modv;
    res  = '0;
    fl   = '0;
    modv = 1 << WIDTH;
    top  = modv - 1;
    for (int k = 0; k < LANES; k++) begin
      a = int'(fx[k*WIDTH +: WIDTH]);
      b = int'(fy[k*WIDTH +: WIDTH]);
      case (f_op)
        2'd0: begin
          v = a + b;
          fl[k] = (v > top);
          if (fl[k]) v = sat ? top : v - modv;
        end
        2'd1: begin
          fl[k] = (a < b);
          v = fl[k] ? (sat ? 0 : a - b + modv) : a - b;
        end
        2'd2: begin
          v = a * b;
          fl[k] = (v > top);
          if (fl[k]) v = sat ? top : v % modv;
        end
        default: v = (a > b) ? a : b;
      endcase
      res[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
    return {fl, res};
  endfunction

  function automatic logic [DW-1:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Transaction logger: predicted results on accept, observed results on delivery.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready0) begin
        exp0_q.push_back(model(op, x, y, 1'b0));
        exp1_q.push_back(model(op, x, y, 1'b1));
      end
      if (out_valid0 && out_ready) obs0_q.push_back({ovf0, r0});
      if (out_valid1 && out_ready) obs1_q.push_back({ovf1, r1});
    end
  end

  task automatic clear_q;
    exp0_q.delete();
    exp1_q.delete();
    obs0_q.delete();
    obs1_q.delete();
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
  endtask

  // Presents one beat (called at posedge+1), returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] s_op, input logic [DW-1:0] sx, input logic [DW-1:0] sy);
    int n = 0;
    op = s_op; x = sx; y = sy; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      $display("FAIL send_accept: in_ready=%0b, want 1", in_ready0);
      in_valid = 1'b0;
    end else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int n);
    int c = 0;
    while (obs0_q.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs0_q.size() != n) $display("FAIL wait_results: got %0d results, want %0d", obs0_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; x = '0; y = '0;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid0); else n_pass++;
    n_checks++; if (r0 !== '0) $display("FAIL reset_r: got %h want 0", r0); else n_pass++;
    n_checks++; if (ovf0 !== 4'd0) $display("FAIL reset_ovf: got %b want 0000", ovf0); else n_pass++;
    n_checks++; if (cnt0 !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cnt0); else n_pass++;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready0); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks latency and both wrap and saturating results.
  task automatic run_beat(input string name, input logic [1:0] b_op, input logic [DW-1:0] bx,
                          input logic [DW-1:0] by, input logic [DW-1:0] er0, input logic [3:0] eo0,
                          input logic [DW-1:0] er1, input logic [3:0] eo1);
    clear_q();
    out_ready = 1'b1;
    send(b_op, bx, by);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL %s_early: out_valid=%0b want 0", name, out_valid0); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL %s_latency: out_valid=%0b want 1", name, out_valid0); else n_pass++;
    n_checks++; if (r0 !== er0) $display("FAIL %s_r: got %h want %h", name, r0, er0); else n_pass++;
    n_checks++; if (ovf0 !== eo0) $display("FAIL %s_ovf: got %b want %b", name, ovf0, eo0); else n_pass++;
    n_checks++; if (r1 !== er1) $display("FAIL %s_r_sat: got %h want %h", name, r1, er1); else n_pass++;
    n_checks++; if (ovf1 !== eo1) $display("FAIL %s_ovf_sat: got %b want %b", name, ovf1, eo1); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    do_reset();
    run_beat("add", 2'd0, pk(2, 4, 6, 8), pk(1, 2, 3, 4),
             pk(3, 6, 9, 12), 4'b0000, pk(3, 6, 9, 12), 4'b0000);
    n_checks++; if (cnt0 !== 16'd1) $display("FAIL add_cnt: got %0d want 1", cnt0); else n_pass++;
  endtask

  task automatic test_saturation;
    run_beat("add_ovf", 2'd0, pk(200, 255, 0, 128), pk(100, 1, 0, 128),
             pk(44, 0, 0, 0), 4'b1011, pk(255, 255, 0, 255), 4'b1011);
    run_beat("sub", 2'd1, pk(3, 5, 7, 9), pk(2, 6, 7, 10),
             pk(1, 255, 0, 255), 4'b1010, pk(1, 0, 0, 0), 4'b1010);
    run_beat("mul", 2'd2, pk(16, 3, 2, 1), pk(16, 5, 2, 255),
             pk(0, 15, 4, 255), 4'b0001, pk(255, 15, 4, 255), 4'b0001);
    run_beat("max", 2'd3, pk(10, 200, 7, 0), pk(20, 100, 7, 255),
             pk(20, 200, 7, 255), 4'b0000, pk(20, 200, 7, 255), 4'b0000);
  endtask

  task automatic test_back_to_back;
    logic [1:0]    b_op[8];
    logic [DW-1:0] b_x[8];
    logic [DW-1:0] b_y[8];
    logic [DW-1:0] prev_r;
    logic [3:0]    prev_ovf;
    bit            prev_stall = 1'b0;
    int            sent = 0;
    int            cyc = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b_op[i] = 2'($urandom_range(0, 3));
      b_x[i]  = $urandom;
      b_y[i]  = $urandom;
    end
    prev_r = '0;
    prev_ovf = '0;
    while ((sent < 8 || obs0_q.size() < 8) && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      if (sent < 8) begin
        in_valid = 1'b1; op = b_op[sent]; x = b_x[sent]; y = b_y[sent];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        n_checks++; if (out_valid0 !== 1'b1) $display("FAIL b2b_hold_valid: got %0b want 1", out_valid0); else n_pass++;
        n_checks++; if (r0 !== prev_r) $display("FAIL b2b_hold_r: got %h want %h", r0, prev_r); else n_pass++;
        n_checks++; if (ovf0 !== prev_ovf) $display("FAIL b2b_hold_ovf: got %b want %b", ovf0, prev_ovf); else n_pass++;
      end
      prev_stall = out_valid0 && !out_ready;
      prev_r = r0;
      prev_ovf = ovf0;
      if (in_valid && in_ready0) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (obs0_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", obs0_q.size()); else n_pass++;
    n_checks++; if (exp0_q.size() != 8) $display("FAIL b2b_accepts: got %0d want 8", exp0_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < obs0_q.size(); i++) begin
      n_checks++;
      if (obs0_q[i] !== model(b_op[i], b_x[i], b_y[i], 1'b0))
        $display("FAIL b2b_beat%0d: got %h want %h", i, obs0_q[i], model(b_op[i], b_x[i], b_y[i], 1'b0));
      else n_pass++;
    end
    n_checks++; if (cnt0 !== 16'd8) $display("FAIL b2b_cnt: got %0d want 8", cnt0); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] cnt_start;
    int c = 0;
    clear_q();
    cnt_start = cnt0;
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (obs0_q.size() < exp0_q.size() && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (obs0_q.size() != exp0_q.size()) $display("FAIL rand_count: got %0d want %0d", obs0_q.size(), exp0_q.size());
    else n_pass++;
    for (int i = 0; i < exp0_q.size() && i < obs0_q.size(); i++) begin
      n_checks++;
      if (obs0_q[i] !== exp0_q[i]) $display("FAIL rand_beat%0d: got %h want %h", i, obs0_q[i], exp0_q[i]);
      else n_pass++;
    end
    for (int i = 0; i < exp1_q.size() && i < obs1_q.size(); i++) begin
      n_checks++;
      if (obs1_q[i] !== exp1_q[i]) $display("FAIL rand_sat_beat%0d: got %h want %h", i, obs1_q[i], exp1_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (cnt0 !== 16'(int'(cnt_start) + exp0_q.size()))
      $display("FAIL rand_cnt: got %0d want %0d", cnt0, 16'(int'(cnt_start) + exp0_q.size()));
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    clear_q();
    out_ready = 1'b0;
    send(2'd0, $urandom, $urandom);
    send(2'd2, $urandom, $urandom);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL rmid_loaded: out_valid=%0b want 1", out_valid0); else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL rmid_out_valid: got %0b want 0", out_valid0); else n_pass++;
    n_checks++; if (cnt0 !== 16'd0) $display("FAIL rmid_cnt: got %0d want 0", cnt0); else n_pass++;
    n_checks++; if (r0 !== '0) $display("FAIL rmid_r: got %h want 0", r0); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (obs0_q.size() != 0) $display("FAIL rmid_stale: got %0d results want 0", obs0_q.size()); else n_pass++;
    n_checks++; if (cnt0 !== 16'd0) $display("FAIL rmid_cnt_after: got %0d want 0", cnt0); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cnt_wrap;
    do_reset();
    for (int i = 0; i < 17; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom);
    in_valid = 1'b0;
    wait_results(17);
    n_checks++; if (cnt2 !== 4'd1) $display("FAIL wrap_cnt4: got %0d want 1", cnt2); else n_pass++;
    n_checks++; if (cnt0 !== 16'd17) $display("FAIL wrap_cnt16: got %0d want 17", cnt0); else n_pass++;
    for (int i = 0; i < 17 && i < obs0_q.size() && i < exp0_q.size(); i++) begin
      n_checks++;
      if (obs0_q[i] !== exp0_q[i]) $display("FAIL wrap_beat%0d: got %h want %h", i, obs0_q[i], exp0_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
